// File: rtl/clcd_pkg.sv
// Shared constants, FSM state type and DDRAM line-address lookup for the
// character-LCD text controller.
package clcd_pkg;

    localparam logic [7:0] CMD_FUNC_2L = 8'h38;
    localparam logic [7:0] CMD_FUNC_1L = 8'h30;
    localparam logic [7:0] CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_DDRAM   = 8'h80;
    localparam logic [7:0] CHAR_BLANK  = 8'h20;

    typedef enum logic [2:0] {
        INIT_WAIT, FUNC_SET, DISP_ON, ENTRY, CLEAR, LINE_ADDR, CHAR, IDLE
    } clcd_state_t;

    function automatic logic [6:0] line_base(input logic [1:0] n);
        case (n)
            2'd0:    return 7'h00;
            2'd1:    return 7'h40;
            2'd2:    return 7'h14;
            default: return 7'h54;
        endcase
    endfunction

    function automatic logic [7:0] line_addr_cmd(input logic [1:0] n);
        return CMD_DDRAM | {1'b0, line_base(n)};
    endfunction

endpackage

// File: rtl/clcd_xfer.sv
// One bus transfer: a setup cycle with E low, E_WIDTH cycles of E high, then
// E low until len cycles have elapsed. done marks the final cycle.
module clcd_xfer #(
    parameter int E_WIDTH = 1
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        start,
    input  logic [15:0] len,
    output logic        e,
    output logic        done
);

    logic [15:0] tcnt;
    logic        busy;

    assign done = busy && (tcnt == len - 16'd1);

    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            tcnt <= '0;
            busy <= 1'b0;
            e    <= 1'b0;
        end else if (start) begin
            tcnt <= '0;
            busy <= 1'b1;
            e    <= 1'b0;
        end else if (done) begin
            busy <= 1'b0;
            e    <= 1'b0;
        end else if (busy) begin
            tcnt <= tcnt + 16'd1;
            e    <= (tcnt + 16'd1) <= 16'(E_WIDTH);
        end
    end

endmodule

// File: rtl/clcd_text_ctrl.sv
// HD44780 text controller: host-writable character buffer, power-up init
// sequence and line-by-line refresh over the 8-bit bus.
module clcd_text_ctrl
    import clcd_pkg::*;
#(
    parameter int NUM_LINES    = 2,
    parameter int COLS         = 16,
    parameter int INIT_DELAY   = 70,
    parameter int CMD_WAIT     = 30,
    parameter int CHAR_WAIT    = 4,
    parameter int CLR_WAIT     = 200,
    parameter int E_WIDTH      = 1,
    parameter int AUTO_REFRESH = 0
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       WR_EN,
    input  logic [1:0] WR_LINE,
    input  logic [5:0] WR_COL,
    input  logic [7:0] WR_CHAR,
    input  logic       CLR_REQ,
    output logic       INIT_DONE,
    output logic       FRAME_DONE,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    localparam logic [7:0] FUNC_CMD = (NUM_LINES == 1) ? CMD_FUNC_1L : CMD_FUNC_2L;

    clcd_state_t state_q;
    logic [31:0] init_cnt;
    logic [1:0]  line_q;
    logic [5:0]  col_q, rd_col;
    logic [7:0]  rd_char;
    logic [NUM_LINES-1:0][COLS-1:0][7:0] buf_q;
    logic        dirty_q, wr_ok;
    logic        xfer_start, xfer_done;
    logic [15:0] xfer_len;
    logic        init_fire, idle_go, last_col, last_line, frame_end, restart, go_line0;

    assign LCD_RW    = 1'b0;
    assign wr_ok     = WR_EN && (int'(WR_LINE) < NUM_LINES) && (int'(WR_COL) < COLS);
    assign init_fire = (state_q == INIT_WAIT) && (init_cnt == 32'(INIT_DELAY - 1));
    assign idle_go   = (state_q == IDLE) && dirty_q;
    assign last_col  = int'(col_q) == COLS - 1;
    assign last_line = int'(line_q) == NUM_LINES - 1;
    assign frame_end = (state_q == CHAR) && xfer_done && last_col && last_line;
    assign restart   = frame_end && ((AUTO_REFRESH != 0) || dirty_q);
    // Every path into the line-0 address command; dirty clears on its setup edge.
    assign go_line0  = ((state_q == CLEAR) && xfer_done) || idle_go || restart;
    assign xfer_start = init_fire || idle_go || (xfer_done && !(frame_end && !restart));

    always_comb begin
        case (state_q)
            CLEAR:   xfer_len = 16'(CLR_WAIT);
            CHAR:    xfer_len = 16'(CHAR_WAIT);
            default: xfer_len = 16'(CMD_WAIT);
        endcase
    end

    // Cell for the next CHAR setup: column 0 after an address, else col+1.
    always_comb begin
        rd_col  = (state_q == CHAR) ? col_q + 6'd1 : 6'd0;
        rd_char = CHAR_BLANK;
        for (int l = 0; l < NUM_LINES; l++)
            for (int c = 0; c < COLS; c++)
                if (int'(line_q) == l && int'(rd_col) == c)
                    rd_char = buf_q[l][c];
    end

    clcd_xfer #(.E_WIDTH(E_WIDTH)) u_xfer (
        .CLK    (CLK),
        .RESETN (RESETN),
        .start  (xfer_start),
        .len    (xfer_len),
        .e      (LCD_E),
        .done   (xfer_done)
    );

    // A host write in the same cycle as a clear overrides that one cell.
    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            for (int l = 0; l < NUM_LINES; l++)
                for (int c = 0; c < COLS; c++)
                    buf_q[l][c] <= CHAR_BLANK;
            dirty_q <= 1'b1;
        end else begin
            for (int l = 0; l < NUM_LINES; l++)
                for (int c = 0; c < COLS; c++) begin
                    if (CLR_REQ)
                        buf_q[l][c] <= CHAR_BLANK;
                    if (wr_ok && int'(WR_LINE) == l && int'(WR_COL) == c)
                        buf_q[l][c] <= WR_CHAR;
                end
            if (wr_ok || CLR_REQ)
                dirty_q <= 1'b1;
            else if (go_line0)
                dirty_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            state_q    <= INIT_WAIT;
            init_cnt   <= '0;
            line_q     <= '0;
            col_q      <= '0;
            LCD_RS     <= 1'b0;
            LCD_DATA   <= 8'h00;
            INIT_DONE  <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            case (state_q)
                INIT_WAIT: begin
                    init_cnt <= init_cnt + 32'd1;
                    if (init_fire) begin
                        state_q  <= FUNC_SET;
                        LCD_RS   <= 1'b0;
                        LCD_DATA <= FUNC_CMD;
                    end
                end
                FUNC_SET: if (xfer_done) begin
                    state_q  <= DISP_ON;
                    LCD_DATA <= CMD_DISP_ON;
                end
                DISP_ON: if (xfer_done) begin
                    state_q  <= ENTRY;
                    LCD_DATA <= CMD_ENTRY;
                end
                ENTRY: if (xfer_done) begin
                    state_q  <= CLEAR;
                    LCD_DATA <= CMD_CLEAR;
                end
                CLEAR: if (xfer_done) begin
                    INIT_DONE <= 1'b1;
                    state_q   <= LINE_ADDR;
                    line_q    <= '0;
                    LCD_DATA  <= line_addr_cmd(2'd0);
                end
                LINE_ADDR: if (xfer_done) begin
                    state_q  <= CHAR;
                    col_q    <= '0;
                    LCD_RS   <= 1'b1;
                    LCD_DATA <= rd_char;
                end
                CHAR: if (xfer_done) begin
                    if (!last_col) begin
                        col_q    <= col_q + 6'd1;
                        LCD_DATA <= rd_char;
                    end else if (!last_line) begin
                        state_q  <= LINE_ADDR;
                        line_q   <= line_q + 2'd1;
                        col_q    <= '0;
                        LCD_RS   <= 1'b0;
                        LCD_DATA <= line_addr_cmd(line_q + 2'd1);
                    end else begin
                        FRAME_DONE <= 1'b1;
                        line_q     <= '0;
                        col_q      <= '0;
                        if (restart) begin
                            state_q  <= LINE_ADDR;
                            LCD_RS   <= 1'b0;
                            LCD_DATA <= line_addr_cmd(2'd0);
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                IDLE: if (dirty_q) begin
                    state_q  <= LINE_ADDR;
                    line_q   <= '0;
                    LCD_RS   <= 1'b0;
                    LCD_DATA <= line_addr_cmd(2'd0);
                end
                default: state_q <= INIT_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_clcd_text_ctrl.sv
// Bench for clcd_text_ctrl: captures every E rising edge as {RS,DATA} and
// compares init timing and refresh frames against a character-grid model.
module tb_clcd_text_ctrl;

    localparam int NL    = 2;
    localparam int NC    = 16;
    localparam int FRAME = NL * (NC + 1);

    logic       CLK = 1'b0;
    logic       RESETN, WR_EN, CLR_REQ;
    logic [1:0] WR_LINE;
    logic [5:0] WR_COL;
    logic [7:0] WR_CHAR;
    logic       INIT_DONE, FRAME_DONE, LCD_E, LCD_RS, LCD_RW;
    logic [7:0] LCD_DATA;

    always #5 CLK = ~CLK;

    clcd_text_ctrl #(
        .NUM_LINES(NL), .COLS(NC), .INIT_DELAY(70), .CMD_WAIT(30), .CHAR_WAIT(4),
        .CLR_WAIT(200), .E_WIDTH(1), .AUTO_REFRESH(0)
    ) dut (
        .CLK(CLK), .RESETN(RESETN), .WR_EN(WR_EN), .WR_LINE(WR_LINE), .WR_COL(WR_COL),
        .WR_CHAR(WR_CHAR), .CLR_REQ(CLR_REQ), .INIT_DONE(INIT_DONE), .FRAME_DONE(FRAME_DONE),
        .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
    );

    int errs = 0, checks = 0;
    int cyc = 0, id_cyc = -1, fd_cnt = 0, wr_edge = 0;
    logic e_prev = 1'b0, id_prev = 1'b0;
    logic [8:0] evq[$];
    int         evc[$];
    logic [7:0] mdl [4][40];
    logic [7:0] base_tab [4];
    bit         acc_any;

    // cyc == k when sampled after the k-th rising edge since reset release
    always @(posedge CLK)
        if (RESETN) cyc <= 0;
        else        cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (LCD_E && !e_prev) begin
            evq.push_back({LCD_RS, LCD_DATA});
            evc.push_back(cyc);
        end
        if (RESETN)                        id_cyc <= -1;
        else if (INIT_DONE && !id_prev)    id_cyc <= cyc;
        if (FRAME_DONE) fd_cnt <= fd_cnt + 1;
        e_prev  <= LCD_E;
        id_prev <= INIT_DONE;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic blank_mdl();
        for (int l = 0; l < 4; l++)
            for (int c = 0; c < 40; c++)
                mdl[l][c] = 8'h20;
    endtask

    function automatic logic [8:0] exp_ev(input int i);
        int ln = i / (NC + 1);
        int k  = i % (NC + 1);
        if (k == 0) return {1'b0, 8'h80 | base_tab[ln]};
        return {1'b1, mdl[ln][k-1]};
    endfunction

    task automatic do_wr(input bit en, input logic [1:0] l, input logic [5:0] c,
                         input logic [7:0] ch, input bit clr);
        @(negedge CLK);
        WR_EN = en; WR_LINE = l; WR_COL = c; WR_CHAR = ch; CLR_REQ = clr;
        @(posedge CLK);
        #1;
        wr_edge = cyc;
        if (clr) begin
            blank_mdl();
            acc_any = 1;
        end
        if (en && int'(l) < NL && int'(c) < NC) begin
            mdl[l][c] = ch;
            acc_any = 1;
        end
        WR_EN = 0; CLR_REQ = 0;
    endtask

    task automatic wait_events(input int n, input int budget);
        int b = 0;
        while (evq.size() < n && b < budget) begin
            @(negedge CLK);
            b++;
        end
        chk("event_count", 32'(evq.size() >= n), 1);
    endtask

    // Wait for a pass to start, then for the bus to stay idle long enough
    // that the last pass has clearly finished.
    task automatic wait_quiet();
        int n0 = evq.size();
        int b  = 0;
        while (evq.size() <= n0 && b < 2000) begin
            @(negedge CLK);
            b++;
        end
        chk("pass_start", 32'(evq.size() > n0), 1);
        b = 0;
        while (evq.size() > 0 && (cyc - evc[evc.size()-1]) <= 150 && b < 4000) begin
            @(negedge CLK);
            b++;
        end
        chk("pass_quiet", 32'(evq.size() > 0 && (cyc - evc[evc.size()-1]) > 150), 1);
    endtask

    task automatic cmp_frame(input int s);
        bit ok = (s >= 0) && (s + FRAME <= evq.size());
        chk("frame_avail", 32'(ok), 1);
        if (ok)
            for (int i = 0; i < FRAME; i++)
                chk($sformatf("frame[%0d]", i), 32'(evq[s+i]), 32'(exp_ev(i)));
    endtask

    initial begin
        int n0, fd0, w, b;
        int         ic[4];
        logic [8:0] iv[4];
        ic = '{71, 101, 131, 161};
        iv = '{9'h038, 9'h00C, 9'h006, 9'h001};
        base_tab = '{8'h00, 8'h40, 8'h14, 8'h54};
        RESETN = 1; WR_EN = 0; CLR_REQ = 0; WR_LINE = 0; WR_COL = 0; WR_CHAR = 0;
        blank_mdl();

        repeat (3) @(posedge CLK);
        #2;
        chk("rst_e", 32'(LCD_E), 0);
        chk("rst_rs", 32'(LCD_RS), 0);
        chk("rst_rw", 32'(LCD_RW), 0);
        chk("rst_data", 32'(LCD_DATA), 0);
        chk("rst_init_done", 32'(INIT_DONE), 0);
        chk("rst_frame_done", 32'(FRAME_DONE), 0);
        @(negedge CLK);
        RESETN = 0;

        // HELLO plus two out-of-range writes, all during init
        do_wr(1, 0, 0, 8'h48, 0);
        do_wr(1, 0, 1, 8'h45, 0);
        do_wr(1, 0, 2, 8'h4C, 0);
        do_wr(1, 0, 3, 8'h4C, 0);
        do_wr(1, 0, 4, 8'h4F, 0);
        do_wr(1, 2, 0, 8'h58, 0);
        do_wr(1, 0, 16, 8'h59, 0);
        wait_events(4 + FRAME, 1500);
        if (evq.size() >= 4)
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("init_cyc[%0d]", i), 32'(evc[i]), 32'(ic[i]));
                chk($sformatf("init_cmd[%0d]", i), 32'(evq[i]), 32'(iv[i]));
            end
        chk("init_done_cyc", 32'(id_cyc), 360);
        cmp_frame(4);
        while (cyc < 620) @(negedge CLK);
        chk("frame_done_once", 32'(fd_cnt), 1);

        // Clean buffer: stays idle; out-of-range writes must not wake it
        n0 = evq.size();
        repeat (1000) @(negedge CLK);
        chk("idle_no_e", 32'(evq.size()), 32'(n0));
        do_wr(1, 2, 5, 8'h5A, 0);
        do_wr(1, 1, 16, 8'h5A, 0);
        do_wr(1, 3, 40, 8'h5A, 0);
        repeat (300) @(negedge CLK);
        chk("oor_no_pass", 32'(evq.size()), 32'(n0));

        do_wr(1, 1, 7, 8'(32'h21 + $urandom_range(0, 90)), 0);
        w = wr_edge;
        wait_events(n0 + 1, 50);
        if (evq.size() > n0) begin
            chk("idle_exit_cyc", 32'(evc[n0]), 32'(w + 2));
            chk("idle_exit_cmd", 32'(evq[n0]), 32'h080);
        end
        wait_quiet();
        cmp_frame(evq.size() - FRAME);

        do_wr(1, 1, 3, 8'h41, 1);
        wait_quiet();
        cmp_frame(evq.size() - FRAME);

        // A write mid-pass leaves dirty set, so exactly one more pass follows
        fd0 = fd_cnt;
        do_wr(1, 0, 2, 8'(32'h21 + $urandom_range(0, 90)), 0);
        repeat (60) @(negedge CLK);
        do_wr(1, 1, 15, 8'(32'h21 + $urandom_range(0, 90)), 0);
        wait_quiet();
        chk("extra_pass", 32'(fd_cnt - fd0), 2);
        cmp_frame(evq.size() - FRAME);

        for (int r = 0; r < 6; r++) begin
            int nw = $urandom_range(1, 6);
            acc_any = 0;
            n0 = evq.size();
            for (int k = 0; k < nw; k++)
                do_wr(1, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 19)),
                      8'(32'h21 + $urandom_range(0, 90)), $urandom_range(0, 7) == 0);
            if (acc_any) begin
                wait_quiet();
                cmp_frame(evq.size() - FRAME);
            end else begin
                repeat (300) @(negedge CLK);
                chk("rand_no_pass", 32'(evq.size()), 32'(n0));
            end
        end

        // Reset in the middle of a character strobe restarts init from scratch
        do_wr(1, 0, 0, 8'h2A, 0);
        b = 0;
        while (!(LCD_E && LCD_RS) && b < 400) begin
            @(negedge CLK);
            b++;
        end
        chk("saw_char_e", 32'(LCD_E && LCD_RS), 1);
        RESETN = 1;
        #1;
        chk("mid_rst_e", 32'(LCD_E), 0);
        chk("mid_rst_init_done", 32'(INIT_DONE), 0);
        chk("mid_rst_data", 32'(LCD_DATA), 0);
        blank_mdl();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n0 = evq.size();
        RESETN = 0;
        wait_events(n0 + 4 + FRAME, 1500);
        if (evq.size() > n0) begin
            chk("rerun_cyc", 32'(evc[n0]), 71);
            chk("rerun_cmd", 32'(evq[n0]), 32'h038);
        end
        chk("rerun_init_done_cyc", 32'(id_cyc), 360);
        cmp_frame(n0 + 4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/clcd_text_ctrl.md
CLCD_TEXT_CTRL -- requirements
Module: clcd_text_ctrl

Interface
REQ-001 SHALL have parameter NUM_LINES, default 2: display lines, legal 1..4.
REQ-002 SHALL have parameter COLS, default 16: characters per line, legal 8..40.
REQ-003 SHALL have parameter INIT_DELAY, default 70: power-up wait in cycles.
REQ-004 SHALL have parameter CMD_WAIT, default 30: cycles per command transfer.
REQ-005 SHALL have parameter CHAR_WAIT, default 4: cycles per character transfer.
REQ-006 SHALL have parameter CLR_WAIT, default 200: cycles for the clear-display transfer.
REQ-007 SHALL have parameter E_WIDTH, default 1: E-high cycles per transfer; each *_WAIT SHALL be at least E_WIDTH+2.
REQ-008 SHALL have parameter AUTO_REFRESH, default 0: 1 = refresh continuously; 0 = refresh only when dirty.
REQ-009 SHALL have port CLK  in  1  clock; all logic on rising edge.
REQ-010 SHALL have port RESETN  in  1  reset; asynchronous, active-high.
REQ-011 SHALL have port WR_EN  in  1  host write strobe, one character per cycle.
REQ-012 SHALL have port WR_LINE  in  2  target line.
REQ-013 SHALL have port WR_COL  in  6  target column.
REQ-014 SHALL have port WR_CHAR  in  8  character code.
REQ-015 SHALL have port CLR_REQ  in  1  one-cycle pulse: blank the whole buffer.
REQ-016 SHALL have port INIT_DONE  out  1  high once the init sequence has completed.
REQ-017 SHALL have port FRAME_DONE  out  1  one-cycle pulse at the end of each refresh pass.
REQ-018 SHALL have ports LCD_E, LCD_RS, LCD_RW (out, 1 each) and LCD_DATA (out, 8): HD44780 8-bit bus.

Function
REQ-019 SHALL hold a NUM_LINES x COLS byte buffer; an accepted write updates its cell in the cycle after WR_EN.
REQ-020 SHALL ignore writes with WR_LINE>=NUM_LINES or WR_COL>=COLS.
REQ-021 SHALL, on CLR_REQ, set every cell to 0x20 in one cycle; if WR_EN is asserted in the same cycle, that write SHALL win for its cell.
REQ-022 SHALL set the dirty flag on any accepted write or CLR_REQ, and clear it at the setup cycle of the line-0 address command.
REQ-023 SHALL run each transfer as: cycle 0 setup (RS/DATA valid, E=0); cycles 1..E_WIDTH E=1; remaining cycles E=0 with RS/DATA held. LCD_RW SHALL always be 0.
REQ-024 SHALL use FSM states INIT_WAIT, FUNC_SET, DISP_ON, ENTRY, CLEAR, LINE_ADDR, CHAR, IDLE.
REQ-025 SHALL implement the init sequence INIT_WAIT(INIT_DELAY) -> FUNC_SET (0x38, or 0x30 if NUM_LINES=1) -> DISP_ON 0x0C -> ENTRY 0x06 -> CLEAR 0x01 (CLR_WAIT) -> LINE_ADDR, and set INIT_DONE when CLEAR ends.
REQ-026 SHALL implement the refresh pass as, for each line n: LINE_ADDR with RS=0 and data 0x80|base(n), base = 0x00/0x40/0x14/0x54; then COLS CHAR transfers with RS=1, data = buffer cell sampled at the setup cycle.
REQ-027 SHALL, after the last character, pulse FRAME_DONE, then go to LINE_ADDR line 0 if AUTO_REFRESH=1 or dirty=1, otherwise go to IDLE.
REQ-028 SHALL leave IDLE for LINE_ADDR line 0 on the cycle after dirty becomes 1.
REQ-029 SHALL let a write during a pass update the buffer immediately; the dirty flag then stays set, so a further pass follows.
REQ-030 SHALL accept writes and CLR_REQ during init; they take effect on the first pass.

Reset
REQ-031 SHALL, on RESETN=1, asynchronously set LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, INIT_DONE=0, FRAME_DONE=0, all buffer cells 0x20, dirty=1, state INIT_WAIT, counters 0.
REQ-032 SHALL abort any transfer in progress when reset is asserted mid-operation; after reset release the full init sequence SHALL restart.

Structure
REQ-033 SHALL place command constants, the state enum and the line-base lookup function in shared package clcd_pkg.
REQ-034 SHALL implement the transfer timing in sub-module clcd_xfer (start, len -> E pulse and done).

Verification
REQ-035 SHALL cover reset release with defaults -> first E rise at cycle 71 with data 0x38; then 0x0C, 0x06, 0x01 at 30-cycle spacing; INIT_DONE high after the 0x01 transfer plus 200 cycles.
REQ-036 SHALL cover writing "HELLO" to line 0 cols 0-4 during init -> first pass shows 0x80 then 0x48,0x45,0x4C,0x4C,0x4F followed by 11 x 0x20; line 1 gets 0xC0 then 16 x 0x20; FRAME_DONE pulses once.
REQ-037 SHALL cover AUTO_REFRESH=0 with no writes after the first pass -> IDLE with no E pulses for 1000 cycles; one write -> a new pass starts the next cycle.
REQ-038 SHALL cover WR_EN to line 1 col 3 with 0x41 in the same cycle as CLR_REQ -> all cells 0x20 except that cell, which holds 0x41.
REQ-039 SHALL cover a write to line 2 with NUM_LINES=2, and a write to col 16 -> buffer unchanged, dirty not set.
REQ-040 SHALL cover reset asserted while E=1 in a CHAR transfer -> E=0 immediately, INIT_DONE=0, and the 0x38 transfer repeats INIT_DELAY cycles after release.
